clk_divider_multi: RTL and testbench

//   Parametrised multi-channel clock divider; successor to the fixed /2 ripple stage chain.

---
 rtl/clk_divider_multi_if.sv | 36 +++
 rtl/clk_divider_multi.sv | 89 ++++++++
 tb/tb_clk_divider_multi.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_divider_multi_if.sv
// Config bus and per-channel outputs of clk_divider_multi.
// master drives enables/divisor writes; slave is the divider.
interface clk_divider_multi_if #(
  parameter int CHANNELS = 4,
  parameter int DIV_W = 16,
  localparam int SEL_W =
    (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic [CHANNELS-1:0] ch_en;
  logic                cfg_wr;
  logic [SEL_W-1:0]    cfg_sel;
  logic [DIV_W-1:0]    cfg_div;
  logic [CHANNELS-1:0] cfg_pending;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] clk_out;

  modport master (
    output ch_en,
    output cfg_wr,
    output cfg_sel,
    output cfg_div,
    input  cfg_pending,
    input  tick,
    input  clk_out
  );

  modport slave (
    input  ch_en,
    input  cfg_wr,
    input  cfg_sel,
    input  cfg_div,
    output cfg_pending,
    output tick,
    output clk_out
  );
endinterface

// File: rtl/clk_divider_multi.sv
// Multi-channel clock divider: registered divided levels and ticks.
// Define CLKDIV_SYNC_EN to add the sync realign port.
module clk_divider_multi #(
  parameter int CHANNELS = 4,
  parameter int DIV_W = 16,
  parameter int DEFAULT_DIV = 2,
  localparam int SEL_W =
    (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input logic clk_system,
  input logic reset,
`ifdef CLKDIV_SYNC_EN
  input logic sync,
`endif
  clk_divider_multi_if.slave bus
);

  logic sync_i;

`ifdef CLKDIV_SYNC_EN
  assign sync_i = sync;
`else
  assign sync_i = 1'b0;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] d_eff;
    logic [DIV_W-1:0] d_m1;
    logic [DIV_W-1:0] half;
    logic             pend;
    logic             tick_q;
    logic             clk_q;
    logic             en;
    logic             wr_hit;
    logic             term;
    logic             realign;
    logic             apply;

    always_comb begin
      d_eff   = (div == '0) ? DIV_W'(1) : div;
      d_m1    = d_eff - DIV_W'(1);
      half    = d_eff >> 1;
      en      = bus.ch_en[g];
      wr_hit  = bus.cfg_wr &&
                (bus.cfg_sel == SEL_W'(g));
      term    = (cnt >= d_m1);
      realign = en && sync_i;
      // a write on the apply edge wins; apply waits
      apply   = pend && !wr_hit &&
                (!en || realign || term);
    end

    always_ff @(posedge clk_system or posedge reset) begin
      if (reset) begin
        div    <= DIV_W'(DEFAULT_DIV);
        shadow <= DIV_W'(DEFAULT_DIV);
        cnt    <= '0;
        pend   <= 1'b0;
        tick_q <= 1'b0;
        clk_q  <= 1'b0;
      end else begin
        if (wr_hit) begin
          shadow <= bus.cfg_div;
          pend   <= 1'b1;
        end else if (apply) begin
          div  <= shadow;
          pend <= 1'b0;
        end
        if (!en || realign) begin
          cnt    <= '0;
          tick_q <= 1'b0;
          clk_q  <= 1'b0;
        end else begin
          clk_q  <= (cnt < half);
          tick_q <= term;
          cnt    <= term ? '0 : cnt + DIV_W'(1);
        end
      end
    end

    assign bus.tick[g]        = tick_q;
    assign bus.clk_out[g]     = clk_q;
    assign bus.cfg_pending[g] = pend;
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Bench for clk_divider_multi: vector table, corner
// sequences and random traffic against a reference model.
`timescale 1ns/1ps
module tb_clk_divider_multi;
  localparam int CH  = 3;
  localparam int DW  = 16;
  localparam int DEF = 2;
  localparam int SW  = 2;

  logic clk_system = 1'b0;
  logic reset = 1'b1;
  logic sync = 1'b0;

  clk_divider_multi_if #(.CHANNELS(CH), .DIV_W(DW)) bus ();

  clk_divider_multi #(
    .CHANNELS(CH),
    .DIV_W(DW),
    .DEFAULT_DIV(DEF)
  ) dut (
    .clk_system(clk_system),
    .reset(reset),
`ifdef CLKDIV_SYNC_EN
    .sync(sync),
`endif
    .bus(bus)
  );

  always #5 clk_system = ~clk_system;

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // reference model: position within period per channel
  int m_div [CH];
  int m_sh  [CH];
  int m_pos [CH];
  logic [CH-1:0] m_pend;
  logic [CH-1:0] m_tick;
  logic [CH-1:0] m_clk;

  typedef struct {
    logic [CH-1:0] en;
    bit            wr;
    int            sel;
    int            div;
    logic [CH-1:0] t;
    logic [CH-1:0] k;
    logic [CH-1:0] p;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(
    logic [CH-1:0] en, bit wr, int sel, int div,
    logic [CH-1:0] t, logic [CH-1:0] k,
    logic [CH-1:0] p);
    vec_t v;
    v.en = en; v.wr = wr; v.sel = sel; v.div = div;
    v.t = t; v.k = k; v.p = p;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_div[c] = DEF;
      m_sh[c]  = DEF;
      m_pos[c] = 0;
    end
    m_pend = '0;
    m_tick = '0;
    m_clk  = '0;
  endtask

  task automatic step();
    logic [CH-1:0] en;
    bit wr;
    bit sy;
    int sel;
    int cd;
    en  = bus.ch_en;
    wr  = bus.cfg_wr;
    sel = int'(bus.cfg_sel);
    cd  = int'(bus.cfg_div);
    sy  = sync;
    @(posedge clk_system);
    for (int c = 0; c < CH; c++) begin
      int d;
      bit hit;
      bit e;
      bit s;
      bit bnd;
      d   = (m_div[c] == 0) ? 1 : m_div[c];
      hit = wr && (sel == c);
      e   = en[c];
      s   = sy && e;
      bnd = !e || s || (m_pos[c] == d - 1);
      if (!e || s) begin
        m_clk[c]  = 1'b0;
        m_tick[c] = 1'b0;
        m_pos[c]  = 0;
      end else begin
        m_clk[c]  = (m_pos[c] < d / 2);
        m_tick[c] = (m_pos[c] == d - 1);
        m_pos[c]  = (m_pos[c] + 1) % d;
      end
      if (hit) begin
        m_sh[c]   = cd;
        m_pend[c] = 1'b1;
      end else if (m_pend[c] && bnd) begin
        m_div[c]  = m_sh[c];
        m_pend[c] = 1'b0;
      end
    end
    #1;
    chk("model_tick", bus.tick, m_tick);
    chk("model_clk_out", bus.clk_out, m_clk);
    chk("model_pending", bus.cfg_pending, m_pend);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.ch_en = '0;
    bus.cfg_wr = 1'b0;
    bus.cfg_sel = '0;
    bus.cfg_div = '0;
    sync = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_system);
    @(negedge clk_system);
    reset = 1'b0;
  endtask

  task automatic cfg_write(input int sel, input int div);
    bus.cfg_wr  = 1'b1;
    bus.cfg_sel = SW'(sel);
    bus.cfg_div = DW'(div);
    step();
    bus.cfg_wr  = 1'b0;
  endtask

  task automatic run_until_tick(input int c,
                                input int limit,
                                output int n,
                                output int hi);
    n = 0;
    hi = 0;
    do begin
      step();
      n++;
      if (bus.clk_out[c]) hi++;
    end while (!bus.tick[c] && n < limit);
  endtask

  initial begin
    int n;
    int hi;
    int tries;
    int together;
    int first;

    tbl[0]  = mk(3'b111, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    tbl[1]  = mk(3'b111, 0, 0, 0, 3'b111, 3'b000, 3'b000);
    tbl[2]  = mk(3'b111, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    tbl[3]  = mk(3'b111, 0, 0, 0, 3'b111, 3'b000, 3'b000);
    tbl[4]  = mk(3'b111, 1, 1, 5, 3'b000, 3'b111, 3'b010);
    tbl[5]  = mk(3'b111, 0, 0, 0, 3'b111, 3'b000, 3'b000);
    tbl[6]  = mk(3'b101, 1, 1, 5, 3'b000, 3'b101, 3'b010);
    tbl[7]  = mk(3'b101, 0, 0, 0, 3'b101, 3'b000, 3'b000);
    tbl[8]  = mk(3'b111, 0, 0, 0, 3'b000, 3'b111, 3'b000);
    tbl[9]  = mk(3'b111, 0, 0, 0, 3'b101, 3'b010, 3'b000);
    tbl[10] = mk(3'b111, 0, 0, 0, 3'b000, 3'b101, 3'b000);
    tbl[11] = mk(3'b111, 0, 0, 0, 3'b101, 3'b000, 3'b000);
    tbl[12] = mk(3'b111, 0, 0, 0, 3'b010, 3'b101, 3'b000);
    tbl[13] = mk(3'b111, 0, 0, 0, 3'b101, 3'b010, 3'b000);
    tbl[14] = mk(3'b111, 1, 3, 7, 3'b000, 3'b111, 3'b000);
    tbl[15] = mk(3'b111, 0, 0, 0, 3'b101, 3'b000, 3'b000);
    tbl[16] = mk(3'b111, 0, 0, 0, 3'b000, 3'b101, 3'b000);
    tbl[17] = mk(3'b111, 0, 0, 0, 3'b111, 3'b000, 3'b000);

    // reset state
    do_reset();
    reset = 1'b1;
    @(posedge clk_system);
    #1;
    chk("reset_tick", bus.tick, 0);
    chk("reset_clk_out", bus.clk_out, 0);
    chk("reset_pending", bus.cfg_pending, 0);
    do_reset();

    // vector table: default /2, odd /5, bad select
    for (int i = 0; i < 18; i++) begin
      bus.ch_en   = tbl[i].en;
      bus.cfg_wr  = tbl[i].wr;
      bus.cfg_sel = SW'(tbl[i].sel);
      bus.cfg_div = DW'(tbl[i].div);
      step();
      chk($sformatf("vec%0d_tick", i),
          bus.tick, tbl[i].t);
      chk($sformatf("vec%0d_clk", i),
          bus.clk_out, tbl[i].k);
      chk($sformatf("vec%0d_pend", i),
          bus.cfg_pending, tbl[i].p);
    end
    bus.cfg_wr = 1'b0;

    // glitch-free update 4 -> 10
    do_reset();
    cfg_write(0, 4);
    step();
    chk("gf_applied", bus.cfg_pending[0], 0);
    bus.ch_en = 3'b001;
    step();
    chk("gf_first_rise", bus.clk_out[0], 1);
    cfg_write(0, 10);
    chk("gf_pend_set", bus.cfg_pending[0], 1);
    step();
    chk("gf_no_tick", bus.tick[0], 0);
    chk("gf_still_pend", bus.cfg_pending[0], 1);
    step();
    chk("gf_tick_at_4", bus.tick[0], 1);
    chk("gf_pend_drop", bus.cfg_pending[0], 0);
    run_until_tick(0, 30, n, hi);
    chk("gf_period_10", n, 10);
    chk("gf_high_5", hi, 5);
    run_until_tick(0, 30, n, hi);
    chk("gf_period_10b", n, 10);

    // D=0 and D=1
    do_reset();
    cfg_write(1, 0);
    cfg_write(2, 1);
    step();
    bus.ch_en = 3'b110;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("d01_tick%0d", i),
          bus.tick, 3'b110);
      chk($sformatf("d01_clk%0d", i),
          bus.clk_out, 3'b000);
    end

    // maximum divisor
    do_reset();
    cfg_write(1, 65535);
    step();
    bus.ch_en = 3'b010;
    run_until_tick(1, 70000, n, hi);
    chk("max_period", n, 65535);
    chk("max_high", hi, 32767);

    // reset mid-count with pending write on ch2
    do_reset();
    cfg_write(2, 6);
    step();
    bus.ch_en = 3'b100;
    tries = 0;
    while (m_pos[2] != 2 && tries < 20) begin
      step();
      tries++;
    end
    chk("rst_reach_cnt", m_pos[2], 2);
    cfg_write(2, 9);
    chk("rst_pre_pend", bus.cfg_pending[2], 1);
    chk("rst_pre_clk", bus.clk_out[2], 1);
    @(negedge clk_system);
    reset = 1'b1;
    #1;
    chk("rst_async_tick", bus.tick, 0);
    chk("rst_async_clk", bus.clk_out, 0);
    chk("rst_async_pend", bus.cfg_pending, 0);
    do_reset();
    bus.ch_en = 3'b100;
    step();
    chk("rst_after_rise", bus.clk_out[2], 1);
    step();
    chk("rst_after_tick", bus.tick[2], 1);
    chk("rst_after_fall", bus.clk_out[2], 0);
    run_until_tick(2, 20, n, hi);
    chk("rst_after_div", n, DEF);

`ifdef CLKDIV_SYNC_EN
    // realign channels at D=3/4/6
    do_reset();
    cfg_write(0, 3);
    cfg_write(1, 4);
    cfg_write(2, 6);
    step();
    bus.ch_en = 3'b001;
    step();
    bus.ch_en = 3'b011;
    repeat (2) step();
    bus.ch_en = 3'b111;
    repeat ($urandom_range(0, 7)) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_clear", bus.clk_out, 0);
    step();
    chk("sync_rise", bus.clk_out, 3'b111);
    together = 0;
    first = 0;
    for (int i = 2; i <= 24; i++) begin
      step();
      if (bus.tick == 3'b111) begin
        together++;
        if (first == 0) first = i;
      end
    end
    chk("sync_common_cnt", together, 2);
    chk("sync_common_first", first, 12);
`endif

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [CH-1:0] en;
      en = bus.ch_en;
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
      bus.ch_en = en;
      bus.cfg_wr = ($urandom_range(0, 3) == 0);
      bus.cfg_sel = SW'($urandom_range(0, 3));
      bus.cfg_div = DW'($urandom_range(0, 9));
`ifdef CLKDIV_SYNC_EN
      sync = ($urandom_range(0, 31) == 0);
`endif
      step();
    end
    bus.cfg_wr = 1'b0;
    sync = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
